// File: rtl/aliens_io_reader_pkg.sv
// Shared constants and types for the aliens I/O read path.
// Port map, idle byte, coin bit positions, reader FSM states.
package aliens_io_pkg;

  localparam int DB_W_DEF     = 4;
  localparam int DB_LIMIT_DEF = 15;

  localparam logic [1:0] ADDR_P1   = 2'd0;
  localparam logic [1:0] ADDR_P2   = 2'd1;
  localparam logic [1:0] ADDR_SYS  = 2'd2;
  localparam logic [1:0] ADDR_COIN = 2'd3;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  localparam int COIN1_BIT = 0;
  localparam int COIN2_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rd_state_e;

  // Active-low coin: an insertion is a 1->0 step.
  function automatic logic [1:0] fall_edge(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/aliens_io_reader_if.sv
// CPU-side read bus of the I/O mapper.
// master = CPU decoder, slave = reader.
interface aliens_io_reader_if;
  logic       cs_n;
  logic       rd_n;
  logic [1:0] addr;
  logic [7:0] dout;
  logic       dout_oe;

  modport master (
    output cs_n,
    output rd_n,
    output addr,
    input  dout,
    input  dout_oe
  );

  modport slave (
    input  cs_n,
    input  rd_n,
    input  addr,
    output dout,
    output dout_oe
  );
endinterface

// File: rtl/aliens_io_reader_debounce.sv
// 8-bit synchroniser plus per-bit debounce.
// Everything advances only on ce.
module io_debounce
  import aliens_io_pkg::*;
#(
  parameter int DB_W     = DB_W_DEF,
  parameter int DB_LIMIT = DB_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       Rn,
  input  logic       ce,
  input  logic [7:0] raw,
  output logic [7:0] stable
);

  localparam logic [DB_W-1:0] LIM_M1 = DB_W'(DB_LIMIT - 1);
  localparam logic [DB_W-1:0] CNT_MAX = '1;

  logic [7:0]           s1;
  logic [7:0]           s2;
  logic [7:0][DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      s1     <= IDLE_BYTE;
      s2     <= IDLE_BYTE;
      stable <= IDLE_BYTE;
      cnt    <= '0;
    end else if (ce) begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 8; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LIM_M1) begin
          // This sample is the DB_LIMIT-th in a row.
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aliens_io_reader.sv
// CPU input reader: debounced switch snapshot on read,
// sticky coin flags cleared by a coin-latch read.
module aliens_io_reader
  import aliens_io_pkg::*;
#(
  parameter int DB_W     = DB_W_DEF,
  parameter int DB_LIMIT = DB_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 Rn,
  input  logic                 ce,
  input  logic [7:0]           in_p1_n,
  input  logic [7:0]           in_p2_n,
  input  logic [7:0]           in_sys_n,
  aliens_io_reader_if.slave    bus,
  output logic [1:0]           coin_pulse
);

  logic [7:0] p1_s;
  logic [7:0] p2_s;
  logic [7:0] sys_s;

  io_debounce #(.DB_W(DB_W), .DB_LIMIT(DB_LIMIT)) u_p1 (
    .clk    (clk),
    .Rn     (Rn),
    .ce     (ce),
    .raw    (in_p1_n),
    .stable (p1_s)
  );

  io_debounce #(.DB_W(DB_W), .DB_LIMIT(DB_LIMIT)) u_p2 (
    .clk    (clk),
    .Rn     (Rn),
    .ce     (ce),
    .raw    (in_p2_n),
    .stable (p2_s)
  );

  io_debounce #(.DB_W(DB_W), .DB_LIMIT(DB_LIMIT)) u_sys (
    .clk    (clk),
    .Rn     (Rn),
    .ce     (ce),
    .raw    (in_sys_n),
    .stable (sys_s)
  );

  rd_state_e  state;
  rd_state_e  state_nx;
  logic [7:0] dout_q;
  logic [7:0] dout_nx;
  logic       oe_q;
  logic       oe_nx;
  logic       coin_rd;
  logic       coin_rd_nx;
  logic [1:0] coin_now;
  logic [1:0] coin_prev;
  logic [1:0] coin_edge;
  logic [1:0] sticky;
  logic [1:0] sticky_nx;
  logic [1:0] clr;
  logic [7:0] rd_mux;
  logic       rd_act;

  assign rd_act    = !bus.cs_n && !bus.rd_n;
  assign coin_now  = {sys_s[COIN2_BIT], sys_s[COIN1_BIT]};
  assign coin_edge = fall_edge(coin_prev, coin_now);

  always_comb begin
    rd_mux = IDLE_BYTE;
    unique case (bus.addr)
      ADDR_P1:   rd_mux = p1_s;
      ADDR_P2:   rd_mux = p2_s;
      ADDR_SYS:  rd_mux = sys_s;
      ADDR_COIN: rd_mux = {6'b0, sticky};
    endcase
  end

  always_comb begin
    state_nx   = state;
    dout_nx    = dout_q;
    oe_nx      = oe_q;
    coin_rd_nx = coin_rd;
    clr        = 2'b00;
    unique case (state)
      IDLE: begin
        if (rd_act) begin
          dout_nx    = rd_mux;
          oe_nx      = 1'b1;
          coin_rd_nx = (bus.addr == ADDR_COIN);
          state_nx   = HOLD;
        end
      end
      HOLD: begin
        if (!rd_act) begin
          oe_nx      = 1'b0;
          coin_rd_nx = 1'b0;
          state_nx   = IDLE;
          // Clear only what the CPU actually saw.
          if (coin_rd) clr = dout_q[1:0];
        end
      end
    endcase
    // A coin edge in the clear cycle must not be lost.
    sticky_nx = (sticky & ~clr) | coin_edge;
  end

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      state      <= IDLE;
      dout_q     <= IDLE_BYTE;
      oe_q       <= 1'b0;
      coin_rd    <= 1'b0;
      coin_prev  <= 2'b11;
      sticky     <= 2'b00;
      coin_pulse <= 2'b00;
    end else begin
      state      <= state_nx;
      dout_q     <= dout_nx;
      oe_q       <= oe_nx;
      coin_rd    <= coin_rd_nx;
      coin_prev  <= coin_now;
      sticky     <= sticky_nx;
      coin_pulse <= coin_edge;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.dout_oe = oe_q;

endmodule

// File: doc/aliens_io_reader.md
Name: aliens_io_reader

Overview:
- CPU-side input reader for the I/O mapper; the read-direction counterpart of the output latch path.
- Takes raw active-low switch inputs (player 1, player 2, system/coin), synchronises and debounces them, and captures a stable snapshot on a decoded CPU read strobe.
- Drives the captured byte on a tri-state-style data output with an enable.
- Produces sticky coin flags and one-cycle coin pulses for the coin-counter logic.

Parameters:
- DB_W, 4, width of each per-bit debounce counter.
- DB_LIMIT, 15, consecutive ce samples of a changed level needed to accept it; must be 1..2^DB_W-1.

Ports:
- clk  in  1  global system clock
- Rn  in  1  asynchronous active-low reset
- ce  in  1  sample clock enable; gates synchroniser advance and debounce counting
- in_p1_n  in  8  raw player-1 switches, active low
- in_p2_n  in  8  raw player-2 switches, active low
- in_sys_n  in  8  raw system switches, active low; bit0 COIN1, bit1 COIN2
- cs_n  in  1  I/O chip select, active low, synchronous to clk
- rd_n  in  1  CPU read strobe, active low, synchronous to clk
- addr  in  2  port select: 0 P1, 1 P2, 2 SYS, 3 COIN latch
- dout  out  8  captured read data
- dout_oe  out  1  data output enable, active high
- coin_pulse  out  2  one-clk pulse per accepted coin insertion

Behaviour:
- Reset (Rn low, async, any state):
  - synchroniser and stable registers 8'hFF (inactive)
  - debounce counters 0; coin sticky 2'b00
  - dout 8'hFF, dout_oe 0, coin_pulse 0, FSM IDLE
- Synchroniser: 2 flops per bit, advance only when ce=1. Input-to-sync latency is 2 ce samples.
- Debounce, per bit:
  - If ce=1 and sync != stable: counter += 1.
  - If ce=1 and sync == stable: counter <= 0.
  - When counter reaches DB_LIMIT on a ce cycle: stable <= sync, counter <= 0.
  - The counter saturates and never wraps.
  - ce=0 freezes all counters and stable values.
- Coin edge:
  - Stable COINx going 1->0 produces coin_pulse[x]=1 for exactly one clk, in the cycle after the stable update.
  - The same edge sets sticky[x].
- rd_act = !cs_n && !rd_n.
- FSM: IDLE, HOLD.
  - IDLE with rd_act: capture mux(addr) into dout, go to HOLD. dout_oe=1 from the next clk, so latency is 1 clk.
  - Mux sources: addr 0 stable P1; 1 stable P2; 2 stable SYS; 3 {6'b0, sticky}.
  - HOLD with rd_act: dout held frozen. Input changes and addr changes are ignored.
  - HOLD with !rd_act: dout_oe <= 0, go to IDLE. dout keeps its last value.
  - If the finished read was addr 3, sticky bits that were captured as 1 are cleared in the same cycle.
  - If a new coin edge occurs in that same cycle, the set wins and the bit stays 1.
- Back-to-back reads need rd_act to deassert for at least 1 clk. No read is captured in the HOLD->IDLE cycle.
- cs_n high with rd_n low is no access: no capture and no oe.

Decomposition:
- Package aliens_io_pkg:
  - port address constants ADDR_P1/P2/SYS/COIN
  - IDLE_BYTE = 8'hFF
  - COIN1_BIT = 0, COIN2_BIT = 1
  - FSM state enum {IDLE, HOLD}
  - default DB_W/DB_LIMIT
- Sub-module io_debounce:
  - one 8-bit vector: synchroniser, counters, stable output
  - same clk/Rn/ce, parameters DB_W, DB_LIMIT
  - instantiated three times
- Top level holds the coin edge/sticky logic, the FSM and the mux.

Test Plan:
- Reset: drive Rn=0 mid-HOLD with dout=8'h5A. Expect immediate dout=8'hFF, dout_oe=0, sticky=0. After release, a read of addr 0 with no input activity returns 8'hFF.
- Debounce accept: with ce=1 every clk, DB_LIMIT=15, hold in_p1_n=8'hFE. Stable bit0 goes to 0 exactly 2+15 clk later; a read of addr 0 then returns 8'hFE.
- Glitch reject: pulse in_p2_n bit3 low for 10 ce samples, then release. A read of addr 1 returns 8'hFF and no counter wraps. Also repeat with ce low half the time and confirm timing doubles.
- Read handshake: cs_n=0, rd_n=0 for 4 clk at addr 2. Expect dout_oe=1 from clk 2 to clk 5, and dout frozen even though in_sys_n and addr change during HOLD. dout_oe=0 the clk after rd_n=1.
- Coin path: a debounced COIN1 press gives coin_pulse=2'b01 for one clk. Read addr 3 returns 8'h01; a second read returns 8'h00.
- Set-vs-clear race: arrange the COIN2 edge on the exact HOLD->IDLE cycle of an addr-3 read that captured sticky=2'b10. Expect sticky[1] to remain 1, and the next addr-3 read to return 8'h02.
